// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, control bundles and hazard FSM states.
package id_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef struct packed {
      logic       reg_dst;
      logic [1:0] alu_op;
      logic       alu_src;
   } ex_ctrl_t;

   typedef struct packed {
      logic branch;
      logic mem_read;
      logic mem_write;
   } m_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;

   typedef enum logic {RUN, STALL} hz_state_t;

endpackage

// File: rtl/id_regfile.sv
// 32-entry register file with hard-wired zero register.
// Optional ID_FORWARD_EN: a same-cycle WB write is bypassed to the read ports (write-first).
module id_regfile #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   logic [XLEN-1:0] r_mem [32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) r_mem[i] <= '0;
      end else if (we && (waddr != 5'd0)) begin
         r_mem[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata1 = (raddr1 == 5'd0) ? '0 : r_mem[raddr1];
      rdata2 = (raddr2 == 5'd0) ? '0 : r_mem[raddr2];
`ifdef ID_FORWARD_EN
      if (we && (waddr != 5'd0) && (waddr == raddr1)) rdata1 = wdata;
      if (we && (waddr != 5'd0) && (waddr == raddr2)) rdata2 = wdata;
`endif
   end

endmodule

// File: rtl/id_stage_p.sv
// MIPS ID stage: decode, register read, branch resolution, load-use hazard FSM, ID/EX register.
// ID_FORWARD_EN selects WB->ID bypass instead of a 1-cycle stall on a same-cycle WB write.
module id_stage_p
   import id_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int LOAD_LAT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] pc,
   input  logic [31:0]     inst_in,
   input  logic            inst_valid,
   input  logic            flush,
   input  logic            wb_reg_write,
   input  logic [4:0]      wb_write_register,
   input  logic [XLEN-1:0] wb_write_data,
   input  logic            ex_mem_read,
   input  logic [4:0]      ex_rt,
   output logic            hold_pc,
   output logic            hold_if,
   output logic            branch_taken,
   output logic [XLEN-1:0] pc_target,
   output logic            exception,
   output logic [3:0]      ex,
   output logic [2:0]      m,
   output logic [1:0]      wb,
   output logic [4:0]      rs,
   output logic [4:0]      rt,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] data_1,
   output logic [XLEN-1:0] data_2,
   output logic            id_valid
);

   localparam logic [1:0] LAT_M1 = 2'(LOAD_LAT - 1);

   logic [5:0]      w_opcode;
   logic [4:0]      w_rs, w_rt, w_rd;
   logic [XLEN-1:0] w_imm, w_rd1, w_rd2;
   ex_ctrl_t        w_ex;
   m_ctrl_t         w_m;
   wb_ctrl_t        w_wb;
   logic            w_undef, w_is_beq, w_is_bne, w_is_j, w_uses_rt;
   logic            w_hz, w_hz_wb, w_fsm_stall, w_stall, w_kill, w_eq;
   hz_state_t       r_state, w_state_nxt;
   logic [1:0]      r_cnt, w_cnt_nxt;

   ex_ctrl_t        r_ex;
   m_ctrl_t         r_m;
   wb_ctrl_t        r_wb;
   logic [4:0]      r_rs, r_rt, r_rd;
   logic [XLEN-1:0] r_imm, r_data_1, r_data_2;
   logic            r_id_valid;

   assign w_opcode = inst_in[31:26];
   assign w_rs     = inst_in[25:21];
   assign w_rt     = inst_in[20:16];
   assign w_rd     = inst_in[15:11];
   assign w_imm    = {{(XLEN-16){inst_in[15]}}, inst_in[15:0]};

   id_regfile #(.XLEN(XLEN)) u_regfile (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (wb_reg_write),
      .waddr  (wb_write_register),
      .wdata  (wb_write_data),
      .raddr1 (w_rs),
      .raddr2 (w_rt),
      .rdata1 (w_rd1),
      .rdata2 (w_rd2)
   );

   always_comb begin
      w_ex      = '0;
      w_m       = '0;
      w_wb      = '0;
      w_undef   = 1'b0;
      w_is_beq  = 1'b0;
      w_is_bne  = 1'b0;
      w_is_j    = 1'b0;
      w_uses_rt = 1'b0;
      case (w_opcode)
         OP_RTYPE: begin
            w_ex = '{reg_dst: 1'b1, alu_op: 2'b10, alu_src: 1'b0};
            w_wb = '{reg_write: 1'b1, mem_to_reg: 1'b0};
            w_uses_rt = 1'b1;
         end
         OP_LW: begin
            w_ex = '{reg_dst: 1'b0, alu_op: 2'b00, alu_src: 1'b1};
            w_m  = '{branch: 1'b0, mem_read: 1'b1, mem_write: 1'b0};
            w_wb = '{reg_write: 1'b1, mem_to_reg: 1'b1};
         end
         OP_SW: begin
            w_ex = '{reg_dst: 1'b0, alu_op: 2'b00, alu_src: 1'b1};
            w_m  = '{branch: 1'b0, mem_read: 1'b0, mem_write: 1'b1};
            w_uses_rt = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            w_ex = '{reg_dst: 1'b0, alu_op: 2'b01, alu_src: 1'b0};
            w_m  = '{branch: 1'b1, mem_read: 1'b0, mem_write: 1'b0};
            w_is_beq  = (w_opcode == OP_BEQ);
            w_is_bne  = (w_opcode == OP_BNE);
            w_uses_rt = 1'b1;
         end
         OP_ADDI: begin
            w_ex = '{reg_dst: 1'b0, alu_op: 2'b00, alu_src: 1'b1};
            w_wb = '{reg_write: 1'b1, mem_to_reg: 1'b0};
         end
         OP_J:    w_is_j  = 1'b1;
         default: w_undef = 1'b1;
      endcase
   end

   assign exception = inst_valid & w_undef;

   // Load-use hazard: only rt-reading opcodes compare against rt
   assign w_hz = ex_mem_read && (ex_rt != 5'd0) &&
                 ((ex_rt == w_rs) || ((ex_rt == w_rt) && w_uses_rt));

`ifdef ID_FORWARD_EN
   assign w_hz_wb = 1'b0;
`else
   assign w_hz_wb = wb_reg_write && (wb_write_register != 5'd0) &&
                    ((wb_write_register == w_rs) || (wb_write_register == w_rt));
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_fsm_stall = 1'b0;
      case (r_state)
         RUN: begin
            if (w_hz && inst_valid) begin
               w_fsm_stall = 1'b1;
               if (LOAD_LAT > 1) begin
                  w_state_nxt = STALL;
                  w_cnt_nxt   = LAT_M1;
               end
            end
         end
         STALL: begin
            w_fsm_stall = 1'b1;
            if (r_cnt == 2'd1) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = 2'd0;
            end else begin
               w_cnt_nxt   = r_cnt - 2'd1;
            end
         end
         default: begin
            w_state_nxt = RUN;
            w_cnt_nxt   = 2'd0;
         end
      endcase
      if (flush) begin
         w_state_nxt = RUN;
         w_cnt_nxt   = 2'd0;
         w_fsm_stall = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RUN;
         r_cnt   <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign w_stall = (w_fsm_stall | (w_hz_wb & inst_valid)) & ~flush;
   assign hold_pc = w_stall;
   assign hold_if = w_stall;

   assign w_eq         = (w_rd1 == w_rd2);
   assign pc_target    = w_is_j ? {pc[XLEN-1:28], inst_in[25:0], 2'b00} : pc + (w_imm << 2);
   assign branch_taken = inst_valid & ~w_stall & ~flush &
                         ((w_is_beq & w_eq) | (w_is_bne & ~w_eq) | w_is_j);

   // ID/EX boundary: bubbles zero control only, operand fields keep their last values
   assign w_kill = w_stall | flush | ~inst_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex       <= '0;
         r_m        <= '0;
         r_wb       <= '0;
         r_id_valid <= 1'b0;
         r_rs       <= '0;
         r_rt       <= '0;
         r_rd       <= '0;
         r_imm      <= '0;
         r_data_1   <= '0;
         r_data_2   <= '0;
      end else if (w_kill) begin
         r_ex       <= '0;
         r_m        <= '0;
         r_wb       <= '0;
         r_id_valid <= 1'b0;
      end else begin
         r_ex       <= w_undef ? '0 : w_ex;
         r_m        <= w_undef ? '0 : w_m;
         r_wb       <= w_undef ? '0 : w_wb;
         r_id_valid <= 1'b1;
         r_rs       <= w_rs;
         r_rt       <= w_rt;
         r_rd       <= w_rd;
         r_imm      <= w_imm;
         r_data_1   <= w_rd1;
         r_data_2   <= w_rd2;
      end
   end

   assign ex       = r_ex;
   assign m        = r_m;
   assign wb       = r_wb;
   assign rs       = r_rs;
   assign rt       = r_rt;
   assign rd       = r_rd;
   assign imm      = r_imm;
   assign data_1   = r_data_1;
   assign data_2   = r_data_2;
   assign id_valid = r_id_valid;

endmodule
